// File: rtl/fxp_divsqrt_unit.sv
// Iterative signed fixed-point divide / square-root engine with a valid/ready
// handshake, one-entry output holding register and request tag pass-through.
module fxp_divsqrt_unit #(
    parameter int WIDTH = 32,
    parameter int FBITS = 8,
    parameter int TAG_W = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz,
    output logic             out_ovf,
    output logic             out_neg,
    output logic             busy
);
    localparam int ITER_D = WIDTH - 1 + FBITS;
    localparam int ITER_S = (WIDTH + FBITS) / 2;
    localparam int SW     = WIDTH + FBITS;
    localparam int CW     = $clog2(ITER_D + 1);
    localparam logic [CW-1:0]    LAST_D   = CW'(ITER_D - 1);
    localparam logic [CW-1:0]    LAST_S   = CW'(ITER_S - 1);
    localparam logic [CW-1:0]    OVF_AT   = CW'(WIDTH - 2);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_SAT  = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, INIT, CALC, ROUND, SIGN} state_t;
    state_t state, state_nx;

    logic              op_r, sgn_r, ovf_r;
    logic [WIDTH-1:0]  a_r, b_r, dvs;
    logic [TAG_W-1:0]  tag_r;
    logic [SW-1:0]     sh;
    logic [SW+1:0]     acc;
    logic [ITER_D-1:0] q;
    logic [CW-1:0]     cnt;

    logic              accept, early, ex_dbz, ex_ovf, ex_neg;
    logic [WIDTH-1:0]  mag_a, mag_b, mag, res_val, ovf_val;
    logic [SW+1:0]     shifted, trial, rshift, dvs_x;
    logic              take, last_iter, div_ovf, rnd_up;
    logic [ITER_D-1:0] q_next;
    logic [WIDTH-1:0]  rounded;

    logic              wr_en, wr_dbz, wr_ovf, wr_neg;
    logic [WIDTH-1:0]  wr_val;
    logic [TAG_W-1:0]  wr_tag;

    assign ex_dbz = !in_op && (in_b == '0);
    assign ex_ovf = !in_op && !ex_dbz && ((in_a == MOST_NEG) || (in_b == MOST_NEG));
    assign ex_neg = in_op && in_a[WIDTH-1];
    assign early  = ex_dbz || ex_ovf || ex_neg;

    // One iteration of restoring division (1 bit) or digit-by-digit root (2 bits)
    always_comb begin
        mag_a   = a_r[WIDTH-1] ? -a_r : a_r;
        mag_b   = b_r[WIDTH-1] ? -b_r : b_r;
        dvs_x   = {{(SW+2-WIDTH){1'b0}}, dvs};
        shifted = '0;
        trial   = '0;
        if (op_r) begin
            shifted = (acc << 2) | {{SW{1'b0}}, sh[SW-1 -: 2]};
            trial   = {1'b0, q, 2'b01};
        end else begin
            shifted = (acc << 1) | {{(SW+1){1'b0}}, sh[SW-1]};
            trial   = dvs_x;
        end
        take      = (shifted >= trial);
        q_next    = {q[ITER_D-2:0], take};
        last_iter = op_r ? (cnt == LAST_S) : (cnt == LAST_D);
        div_ovf   = (state == CALC) && !op_r && (cnt == OVF_AT) && (|q_next[WIDTH-2 -: FBITS]);
        rshift    = acc << 1;
        rnd_up    = (rshift >= dvs_x) && (q[0] || (rshift != dvs_x));
        rounded   = q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, rnd_up};
        mag       = q[WIDTH-1:0];
        res_val   = (sgn_r && (mag != '0)) ? -mag : mag;
        ovf_val   = SAT ? (sgn_r ? NEG_SAT : MOST_POS) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = early ? IDLE : INIT;
            INIT:    state_nx = CALC;
            CALC:    if (div_ovf)        state_nx = IDLE;
                     else if (last_iter) state_nx = op_r ? SIGN : ROUND;
            ROUND:   state_nx = SIGN;
            SIGN:    if (!out_valid || out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake and result-write selection; SIGN holds until the output slot is free
    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready);
        busy     = (state != IDLE);
        accept   = in_valid && in_ready;
        wr_en    = 1'b0;
        wr_val   = '0;
        wr_tag   = tag_r;
        wr_dbz   = 1'b0;
        wr_ovf   = 1'b0;
        wr_neg   = 1'b0;
        if (accept && early) begin
            wr_en  = 1'b1;
            wr_tag = in_tag;
            wr_dbz = ex_dbz;
            wr_ovf = ex_ovf;
            wr_neg = ex_neg;
        end else if (div_ovf) begin
            wr_en  = 1'b1;
            wr_ovf = 1'b1;
            wr_val = ovf_val;
        end else if ((state == SIGN) && (!out_valid || out_ready)) begin
            wr_en  = 1'b1;
            wr_ovf = ovf_r;
            wr_val = ovf_r ? ovf_val : res_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r  <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            tag_r <= '0;
            sgn_r <= 1'b0;
            ovf_r <= 1'b0;
            dvs   <= '0;
            sh    <= '0;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                op_r  <= in_op;
                a_r   <= in_a;
                b_r   <= in_b;
                tag_r <= in_tag;
            end
            case (state)
                INIT: begin
                    sh    <= op_r ? {a_r, {FBITS{1'b0}}} : ({mag_a, {FBITS{1'b0}}} << 1);
                    dvs   <= mag_b;
                    sgn_r <= !op_r && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    ovf_r <= 1'b0;
                    acc   <= '0;
                    q     <= '0;
                    cnt   <= '0;
                end
                CALC: begin
                    sh  <= op_r ? (sh << 2) : (sh << 1);
                    acc <= take ? (shifted - trial) : shifted;
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                end
                ROUND: begin
                    // A round-up carrying into the sign bit is still an overflow
                    q     <= {{(ITER_D-WIDTH){1'b0}}, rounded};
                    ovf_r <= rounded[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_val   <= '0;
            out_tag   <= '0;
            out_dbz   <= 1'b0;
            out_ovf   <= 1'b0;
            out_neg   <= 1'b0;
        end else if (wr_en) begin
            out_valid <= 1'b1;
            out_val   <= wr_val;
            out_tag   <= wr_tag;
            out_dbz   <= wr_dbz;
            out_ovf   <= wr_ovf;
            out_neg   <= wr_neg;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fxp_divsqrt_unit.sv
// Directed-vector bench for fxp_divsqrt_unit: a SAT=0 and a SAT=1 instance
// share all inputs; vectors carry hand-computed results, flags and latency.
module tb_fxp_divsqrt_unit;
    localparam int WIDTH = 32;
    localparam int FBITS = 8;
    localparam int TAG_W = 4;
    localparam int NVEC  = 18;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_op = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;

    logic             in_ready, out_valid, out_dbz, out_ovf, out_neg, busy;
    logic [WIDTH-1:0] out_val;
    logic [TAG_W-1:0] out_tag;
    logic             s_in_ready, s_out_valid, s_out_dbz, s_out_ovf, s_out_neg, s_busy;
    logic [WIDTH-1:0] s_out_val;
    logic [TAG_W-1:0] s_out_tag;

    fxp_divsqrt_unit #(.WIDTH(WIDTH), .FBITS(FBITS), .TAG_W(TAG_W), .SAT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val), .out_tag(out_tag),
        .out_dbz(out_dbz), .out_ovf(out_ovf), .out_neg(out_neg), .busy(busy)
    );

    fxp_divsqrt_unit #(.WIDTH(WIDTH), .FBITS(FBITS), .TAG_W(TAG_W), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_val(s_out_val), .out_tag(s_out_tag),
        .out_dbz(s_out_dbz), .out_ovf(s_out_ovf), .out_neg(s_out_neg), .busy(s_busy)
    );

    always #5 clk = ~clk;

    // lat: edges from accept to out_valid (0 = written on the accept edge, -1 = not checked)
    typedef struct packed {
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] val;
        logic [WIDTH-1:0] sat_val;
        logic [2:0]       flags;
        int               lat;
    } vec_t;

    vec_t vecs [NVEC];
    int   checks = 0;
    int   errors = 0;

    task automatic check_output(input string name, input logic [WIDTH-1:0] got,
                                input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                                  output int lat);
        int wait_cnt;
        wait_cnt = 0;
        @(negedge clk);
        while (!in_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{1'b0, 32'h0000_0600, 32'h0000_0200, 4'd3,  32'h0000_0300, 32'h0000_0300, 3'b000, 42};
        vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0000_0300, 4'd1,  32'h0000_0055, 32'h0000_0055, 3'b000, 42};
        vecs[2]  = '{1'b0, 32'hFFFF_F900, 32'h0000_0200, 4'd2,  32'hFFFF_FC80, 32'hFFFF_FC80, 3'b000, 42};
        vecs[3]  = '{1'b0, 32'h0000_0180, 32'h0010_0000, 4'd4,  32'h0000_0000, 32'h0000_0000, 3'b000, 42};
        vecs[4]  = '{1'b0, 32'h0000_0001, 32'h0000_0200, 4'd5,  32'h0000_0000, 32'h0000_0000, 3'b000, 42};
        vecs[5]  = '{1'b0, 32'h0000_0003, 32'h0000_0200, 4'd6,  32'h0000_0002, 32'h0000_0002, 3'b000, 42};
        vecs[6]  = '{1'b0, 32'h0000_0005, 32'h0000_0200, 4'd7,  32'h0000_0002, 32'h0000_0002, 3'b000, 42};
        vecs[7]  = '{1'b0, 32'h0000_0100, 32'hFFFF_FD00, 4'd8,  32'hFFFF_FFAB, 32'hFFFF_FFAB, 3'b000, 42};
        vecs[8]  = '{1'b0, 32'hFFFF_FA00, 32'hFFFF_FE00, 4'd9,  32'h0000_0300, 32'h0000_0300, 3'b000, 42};
        vecs[9]  = '{1'b1, 32'h0000_0200, 32'h0000_0000, 4'd10, 32'h0000_016A, 32'h0000_016A, 3'b000, 22};
        vecs[10] = '{1'b1, 32'h0000_0900, 32'h0000_0000, 4'd11, 32'h0000_0300, 32'h0000_0300, 3'b000, 22};
        vecs[11] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 4'd12, 32'h0000_0000, 32'h0000_0000, 3'b000, 22};
        vecs[12] = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 4'd13, 32'h000B_504F, 32'h000B_504F, 3'b000, 22};
        vecs[13] = '{1'b1, 32'hFFFF_FF00, 32'h0000_0000, 4'd14, 32'h0000_0000, 32'h0000_0000, 3'b001, 0};
        vecs[14] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'd15, 32'h0000_0000, 32'h0000_0000, 3'b100, 0};
        vecs[15] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 4'd0,  32'h0000_0000, 32'h0000_0000, 3'b010, 0};
        vecs[16] = '{1'b0, 32'h7FFF_FF00, 32'h0000_0001, 4'd1,  32'h0000_0000, 32'h7FFF_FFFF, 3'b010, -1};
        vecs[17] = '{1'b0, 32'h8000_0100, 32'h0000_0001, 4'd2,  32'h0000_0000, 32'h8000_0001, 3'b010, -1};

        #1;
        check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        check_output("reset_out_val", out_val, 32'd0);
        #21;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, lat);
            check_output($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
            check_output($sformatf("v%0d_val", i), out_val, vecs[i].val);
            check_output($sformatf("v%0d_tag", i), {28'b0, out_tag}, {28'b0, vecs[i].tag});
            check_output($sformatf("v%0d_flags", i), {29'b0, out_dbz, out_ovf, out_neg},
                         {29'b0, vecs[i].flags});
            check_output($sformatf("v%0d_sat_val", i), s_out_val, vecs[i].sat_val);
            if (vecs[i].lat >= 0)
                check_output($sformatf("v%0d_latency", i), lat, vecs[i].lat);
        end

        // Back-pressure: result must hold and block new requests until consumed
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        apply_stimulus(1'b0, 32'h600, 32'h200, 4'hA, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("bp_valid", {31'b0, out_valid}, 32'd1);
            check_output("bp_val", out_val, 32'h300);
            check_output("bp_tag", {28'b0, out_tag}, 32'hA);
            check_output("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = 1'b1;
        in_a      = 32'h900;
        in_b      = 32'h0;
        in_tag    = 4'hB;
        out_ready = 1'b1;
        #1;
        check_output("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_output("bp_cleared", {31'b0, out_valid}, 32'd0);
        check_output("bp_accepted_busy", {31'b0, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output("bp_next_latency", lat, 22);
        check_output("bp_next_val", out_val, 32'h300);
        check_output("bp_next_tag", {28'b0, out_tag}, 32'hB);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 1'b0;
        in_a     = 32'h600;
        in_b     = 32'h200;
        in_tag   = 4'h5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check_output("mid_busy_before_reset", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("rst_busy", {31'b0, busy}, 32'd0);
        check_output("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
        #13;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_output("rst_no_result", seen, 0);
        check_output("rst_in_ready_after", {31'b0, in_ready}, 32'd1);

        apply_stimulus(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].tag, lat);
        check_output("post_rst_val", out_val, vecs[0].val);
        check_output("post_rst_latency", lat, vecs[0].lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
